// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cam_pkg                                                    |
// | Brief   : Shared types and constants for the camera frame grabber.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cam_pkg;

    // Default frame-buffer address width (128 KiB buffer).
    localparam int CAM_ADDR_W_DEFAULT = 17;

    // Line counter saturation value.
    localparam logic [11:0] LINE_CNT_MAX = 12'hFFF;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_e;

    // The controller counts as busy while waiting for or capturing a frame.
    function automatic logic is_busy(input cam_state_e s);
        return (s == ST_WAIT_VS) || (s == ST_CAPTURE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cam_sync_edge                                              |
// | Brief   : 2-flop synchronizer with rising/falling edge detection.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cam_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchronizer followed by one history flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/cam_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cam_frame_ctrl                                             |
// | Brief   : Single-frame camera capture controller writing bytes into  |
// |           a frame buffer, with overflow, line count and interrupt.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cam_frame_ctrl
    import cam_pkg::*;
#(
    parameter int ADDR_W = CAM_ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_arm,
    input  logic              cmd_abort,
    input  logic              cmd_ack,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_pclk,
    input  logic [7:0]        cam_data,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic [ADDR_W:0]   frame_len,
    output logic [11:0]       line_cnt,
    output logic              ovf,
    output logic              busy,
    output logic              int_n
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Synchronized camera controls and their edges.
    logic vs_lvl, vs_rise, vs_fall;
    logic href_lvl, href_rise, href_fall;
    logic pclk_lvl, pclk_rise, pclk_fall;

    cam_sync_edge u_sync_vsync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (cam_vsync),
        .sync_o  (vs_lvl),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    cam_sync_edge u_sync_href (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (cam_href),
        .sync_o  (href_lvl),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    cam_sync_edge u_sync_pclk (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (cam_pclk),
        .sync_o  (pclk_lvl),
        .rise_o  (pclk_rise),
        .fall_o  (pclk_fall)
    );

    // Only some level/edge outputs drive logic; the rest are sunk here.
    logic unused_sync;
    assign unused_sync = ^{vs_lvl, href_rise, pclk_lvl, pclk_fall};

    logic [7:0]        data_d1_q;
    logic [7:0]        data_d2_q;
    cam_state_e        state_q;
    logic [ADDR_W:0]   ptr_q;
    logic              buf_wr_en_q;
    logic [ADDR_W-1:0] buf_wr_addr_q;
    logic [7:0]        buf_wr_data_q;
    logic [ADDR_W:0]   frame_len_q;
    logic [11:0]       line_cnt_q;
    logic              ovf_q;
    logic              int_n_q;

    // A new capture starts from IDLE on arm, or from DONE on arm plus ack.
    logic w_start;
    assign w_start = !cmd_abort && cmd_arm &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && cmd_ack));

    // Pixel data delayed to stay aligned with the synchronized controls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_d1_q <= 8'd0;
            data_d2_q <= 8'd0;
        end else begin
            data_d1_q <= cam_data;
            data_d2_q <= data_d1_q;
        end
    end

    // Capture FSM with all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_addr_q <= '0;
            buf_wr_data_q <= 8'd0;
            frame_len_q   <= '0;
            line_cnt_q    <= 12'd0;
            ovf_q         <= 1'b0;
            int_n_q       <= 1'b1;
        end else begin
            buf_wr_en_q <= 1'b0;
            if (cmd_abort) begin
                // Abort keeps the status of the interrupted frame.
                state_q <= ST_IDLE;
                int_n_q <= 1'b1;
            end else if (w_start) begin
                state_q     <= ST_WAIT_VS;
                int_n_q     <= 1'b1;
                ptr_q       <= '0;
                frame_len_q <= '0;
                line_cnt_q  <= 12'd0;
                ovf_q       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_WAIT_VS: begin
                        // A vsync fall marks the start of a complete frame.
                        if (vs_fall) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (vs_rise) begin
                            state_q     <= ST_DONE;
                            frame_len_q <= ptr_q;
                            int_n_q     <= 1'b0;
                        end else if (pclk_rise && href_lvl) begin
                            // Pointer MSB set means the buffer is full.
                            if (!ptr_q[ADDR_W]) begin
                                buf_wr_en_q   <= 1'b1;
                                buf_wr_addr_q <= ptr_q[ADDR_W-1:0];
                                buf_wr_data_q <= data_d2_q;
                                ptr_q         <= ptr_q + PTR_ONE;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                        if (href_fall && (line_cnt_q != LINE_CNT_MAX)) begin
                            line_cnt_q <= line_cnt_q + 12'd1;
                        end
                    end
                    ST_DONE: begin
                        if (cmd_ack) begin
                            state_q <= ST_IDLE;
                            int_n_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        int_n_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign busy        = is_busy(state_q);
    assign buf_wr_en   = buf_wr_en_q;
    assign buf_wr_addr = buf_wr_addr_q;
    assign buf_wr_data = buf_wr_data_q;
    assign frame_len   = frame_len_q;
    assign line_cnt    = line_cnt_q;
    assign ovf         = ovf_q;
    assign int_n       = int_n_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_cam_frame_ctrl                                          |
// | Brief   : Scoreboard bench; a full-size and a 16-byte controller     |
// |           watch the same camera stream and commands.                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_cam_frame_ctrl;

    localparam int AW  = 17;
    localparam int AWS = 4;
    localparam int CAP_S = 16;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic cmd_arm = 1'b0, cmd_abort = 1'b0, cmd_ack = 1'b0;
    logic cam_vsync = 1'b1, cam_href = 1'b0, cam_pclk = 1'b0;
    logic [7:0] cam_data = 8'd0;

    logic          buf_wr_en, ovf, busy, int_n;
    logic [AW-1:0] buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic [AW:0]   frame_len;
    logic [11:0]   line_cnt;

    logic           s_wr_en, s_ovf, s_busy, s_int_n;
    logic [AWS-1:0] s_wr_addr;
    logic [7:0]     s_wr_data;
    logic [AWS:0]   s_frame_len;
    logic [11:0]    s_line_cnt;

    cam_frame_ctrl #(.ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .cmd_ack(cmd_ack),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .cam_data(cam_data),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .frame_len(frame_len), .line_cnt(line_cnt), .ovf(ovf), .busy(busy), .int_n(int_n)
    );

    cam_frame_ctrl #(.ADDR_W(AWS)) dut_s (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .cmd_ack(cmd_ack),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk), .cam_data(cam_data),
        .buf_wr_en(s_wr_en), .buf_wr_addr(s_wr_addr), .buf_wr_data(s_wr_data),
        .frame_len(s_frame_len), .line_cnt(s_line_cnt), .ovf(s_ovf), .busy(s_busy), .int_n(s_int_n)
    );

    always #5 clk_i = ~clk_i;
    always #43.7 cam_pclk = ~cam_pclk;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues: expected writes for each controller.
    int exp_addr_q[$];
    int exp_data_q[$];
    int exps_addr_q[$];
    int exps_data_q[$];

    // Reference model: armed for next frame, capturing, frame complete.
    bit m_armed = 0, m_cap = 0, m_done = 0;
    int m_cnt = 0;
    int exp_len = 0, exp_lines = 0;
    bit exp_ovf_s = 0;

    realtime t_rise = 0.0;
    always @(posedge cam_pclk) t_rise = $realtime;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (buf_wr_en) begin
            chk("write_expected", 32'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) begin
                chk("wr_addr", 32'(buf_wr_addr), exp_addr_q.pop_front());
                chk("wr_data", 32'(buf_wr_data), exp_data_q.pop_front());
                chk("wr_latency", 32'(($realtime - t_rise) >= 24.5 && ($realtime - t_rise) <= 35.5), 1);
            end
        end
        if (s_wr_en) begin
            chk("s_write_expected", 32'(exps_addr_q.size() > 0), 1);
            if (exps_addr_q.size() > 0) begin
                chk("s_wr_addr", 32'(s_wr_addr), exps_addr_q.pop_front());
                chk("s_wr_data", 32'(s_wr_data), exps_data_q.pop_front());
            end
        end
    end

    task automatic model_start();
        m_armed = 1; m_cnt = 0; exp_len = 0; exp_lines = 0; exp_ovf_s = 0;
    endtask

    task automatic pulse(input bit arm, input bit ack, input bit abort);
        @(negedge clk_i);
        cmd_arm = arm; cmd_ack = ack; cmd_abort = abort;
        @(negedge clk_i);
        cmd_arm = 0; cmd_ack = 0; cmd_abort = 0;
        if (abort) begin
            m_armed = 0; m_cap = 0; m_done = 0;
        end else if (m_done) begin
            if (ack) begin
                m_done = 0;
                if (arm) model_start();
            end
        end else if (!m_armed && !m_cap && arm) begin
            model_start();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".int_n"}, 32'(int_n), 1);
        chk({tag, ".wr_en"}, 32'(buf_wr_en), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".ovf"}, 32'(ovf), 0);
        chk({tag, ".frame_len"}, 32'(frame_len), 0);
        chk({tag, ".line_cnt"}, 32'(line_cnt), 0);
        chk({tag, ".wr_addr"}, 32'(buf_wr_addr), 0);
        chk({tag, ".wr_data"}, 32'(buf_wr_data), 0);
        chk({tag, ".s_ovf"}, 32'(s_ovf), 0);
        chk({tag, ".s_frame_len"}, 32'(s_frame_len), 0);
    endtask

    task automatic do_reset();
        rst_n_i = 0;
        #1;
        check_reset("rst_mid");
        m_armed = 0; m_cap = 0; m_done = 0;
        exp_len = 0; exp_lines = 0; exp_ovf_s = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1;
    endtask

    task automatic check_status(input string tag, input bit exp_intn, input bit exp_busy);
        @(negedge clk_i);
        chk({tag, ".frame_len"}, 32'(frame_len), exp_len);
        chk({tag, ".s_frame_len"}, 32'(s_frame_len), (exp_len > CAP_S) ? CAP_S : exp_len);
        chk({tag, ".line_cnt"}, 32'(line_cnt), exp_lines);
        chk({tag, ".s_line_cnt"}, 32'(s_line_cnt), exp_lines);
        chk({tag, ".ovf"}, 32'(ovf), 0);
        chk({tag, ".s_ovf"}, 32'(s_ovf), exp_ovf_s);
        chk({tag, ".int_n"}, 32'(int_n), exp_intn);
        chk({tag, ".s_int_n"}, 32'(s_int_n), exp_intn);
        chk({tag, ".busy"}, 32'(busy), exp_busy);
        chk({tag, ".s_busy"}, 32'(s_busy), exp_busy);
    endtask

    // cmd_kind: 0 none, 1 arm, 2 abort, 3 reset -- issued as byte cmd_at is presented.
    task automatic send_frame(input int nl, input int nb, input int cmd_kind, input int cmd_at);
        int idx = 0;
        repeat (2) @(negedge cam_pclk);
        cam_vsync = 0;
        if (m_armed) begin
            m_armed = 0;
            m_cap = 1;
        end
        repeat (3) @(negedge cam_pclk);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb; b++) begin
                @(negedge cam_pclk);
                cam_href = 1;
                cam_data = 8'($urandom);
                if (idx == cmd_at) begin
                    case (cmd_kind)
                        1: pulse(1, 0, 0);
                        2: pulse(0, 0, 1);
                        3: do_reset();
                        default: ;
                    endcase
                end
                if (m_cap) begin
                    exp_addr_q.push_back(m_cnt);
                    exp_data_q.push_back(int'(cam_data));
                    if (m_cnt < CAP_S) begin
                        exps_addr_q.push_back(m_cnt);
                        exps_data_q.push_back(int'(cam_data));
                    end else begin
                        exp_ovf_s = 1;
                    end
                    m_cnt++;
                end
                idx++;
            end
            @(negedge cam_pclk);
            cam_href = 0;
            if (m_cap) exp_lines++;
            repeat (2) @(negedge cam_pclk);
        end
        @(negedge cam_pclk);
        cam_vsync = 1;
        if (m_cap) begin
            m_cap = 0;
            m_done = 1;
            exp_len = m_cnt;
        end
        repeat (12) @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check_reset("reset");
        rst_n_i = 1;
        repeat (4) @(negedge clk_i);

        // Basic 4x6 frame (small controller overflows at 16).
        pulse(1, 0, 0);
        check_status("armed", 1, 1);
        send_frame(4, 6, 0, -1);
        check_status("frame4x6", 0, 0);
        pulse(0, 1, 0);
        check_status("ack", 1, 0);

        // Arm in the middle of a frame: that frame is skipped.
        send_frame(3, 5, 1, 3);
        check_status("midarm_wait", 1, 1);
        send_frame(3, 5, 0, -1);
        check_status("midarm_next", 0, 0);
        pulse(0, 1, 0);

        // 20-byte frame: small controller keeps 16 and flags overflow.
        pulse(1, 0, 0);
        send_frame(4, 5, 0, -1);
        check_status("ovf20", 0, 0);
        pulse(0, 1, 0);

        // Abort at byte 10.
        pulse(1, 0, 0);
        send_frame(3, 6, 2, 10);
        check_status("abort", 1, 0);

        // DONE: arm alone ignored, then ack+arm restarts directly.
        pulse(1, 0, 0);
        send_frame(2, 4, 0, -1);
        pulse(1, 0, 0);
        check_status("done_arm_ignored", 0, 0);
        pulse(1, 1, 0);
        check_status("ack_arm", 1, 1);
        send_frame(2, 3, 0, -1);
        check_status("ack_arm_frame", 0, 0);
        pulse(0, 1, 0);

        // Reset in the middle of capture; no writes until re-armed.
        pulse(1, 0, 0);
        send_frame(3, 6, 3, 8);
        send_frame(2, 3, 0, -1);
        check_status("post_reset", 1, 0);
        pulse(1, 0, 0);
        send_frame(2, 2, 0, -1);
        check_status("rearm", 0, 0);

        // Randomized frames and restart styles.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse(1, 1, 0);
            end else begin
                pulse(0, 1, 0);
                pulse(1, 0, 0);
            end
            send_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 10)), 0, -1);
            check_status("random", 0, 0);
        end
        pulse(0, 1, 0);
        check_status("final", 1, 0);

        repeat (20) @(negedge clk_i);
        chk("exp_q_drained", 32'(exp_addr_q.size()), 0);
        chk("exps_q_drained", 32'(exps_addr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_frame_ctrl.md
CAM_FRAME_CTRL -- requirements
Module: cam_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame-buffer address width (capacity 2**ADDR_W bytes).
REQ-002 SHALL have ports:
- clk_i  in  1  system clock; single clock domain
- rst_n_i  in  1  asynchronous, active-low reset
- cmd_arm  in  1  one-cycle pulse; arm capture of the next frame
- cmd_abort  in  1  one-cycle pulse; abandon the current operation
- cmd_ack  in  1  one-cycle pulse; host has read out the frame
- cam_vsync  in  1  raw camera vsync, active high, asynchronous
- cam_href  in  1  raw camera href, active high, asynchronous
- cam_pclk  in  1  raw camera pixel clock, asynchronous
- cam_data  in  8  raw camera data
- buf_wr_en  out  1  one-cycle byte write strobe
- buf_wr_addr  out  ADDR_W  byte address for this write
- buf_wr_data  out  8  byte to write
- frame_len  out  ADDR_W+1  bytes stored in the last frame
- line_cnt  out  12  href lines seen in the current or last frame
- ovf  out  1  last frame exceeded buffer capacity
- busy  out  1  high in WAIT_VS or CAPTURE
- int_n  out  1  active-low frame-ready interrupt

Function
REQ-003 SHALL pass cam_vsync, cam_href and cam_pclk through 2-flop synchronizers, and cam_data through a matching 2-stage delay.
REQ-004 SHALL detect synchronized edges: pclk rising, vsync rising, vsync falling, href falling.
REQ-005 SHALL require clk_i >= 4x cam_pclk; below this ratio, behaviour is undefined.
REQ-006 SHALL implement the FSM states IDLE, WAIT_VS, CAPTURE and DONE.
REQ-007 IDLE: on cmd_arm, go to WAIT_VS; clear frame_len, line_cnt and ovf, and zero the write pointer.
REQ-008 WAIT_VS: on a vsync falling edge, go to CAPTURE. A frame already in progress at arm time SHALL never be captured.
REQ-009 CAPTURE: on each pclk rising edge with synchronized href=1, write one byte.
REQ-010 Each write SHALL assert buf_wr_en for exactly one clk_i cycle, 3 clk_i cycles after the raw pclk rising edge.
REQ-011 Each write SHALL use buf_wr_addr equal to the write pointer, then increment the pointer.
REQ-012 CAPTURE: on each href falling edge, increment line_cnt, saturating at 4095.
REQ-013 CAPTURE: on a vsync rising edge, go to DONE and load frame_len from the write pointer. The same cycle SHALL not write a byte.
REQ-014 Overflow: when the pointer reaches 2**ADDR_W, later bytes SHALL be dropped (no buf_wr_en) and ovf SHALL be set.
REQ-015 Overflow: capture SHALL continue to the vsync rising edge; frame_len then equals 2**ADDR_W.
REQ-016 DONE: int_n SHALL be low, from the cycle after entering DONE until DONE is left.
REQ-017 DONE: cmd_ack alone SHALL go to IDLE; cmd_arm alone SHALL be ignored.
REQ-018 DONE: cmd_ack together with cmd_arm SHALL go straight to WAIT_VS with the REQ-007 clears.
REQ-019 cmd_abort in any state SHALL go to IDLE on the next cycle, with int_n high and no further buf_wr_en.
REQ-020 cmd_abort SHALL keep frame_len, line_cnt and ovf, and SHALL override any simultaneous cmd_arm or cmd_ack.
REQ-021 cmd_arm in WAIT_VS or CAPTURE SHALL be ignored.
REQ-022 busy SHALL be combinationally decoded from the state; all other outputs SHALL be registered.

Reset
REQ-023 On rst_n_i low, asynchronously: state IDLE; int_n=1; buf_wr_en=0; busy=0; ovf=0.
REQ-024 On rst_n_i low, asynchronously: buf_wr_addr, buf_wr_data, frame_len, line_cnt, the pointer and all synchronizer flops = 0.
REQ-025 Reset mid-CAPTURE SHALL stop writes immediately; after release, capture needs a new cmd_arm.

Structure
REQ-026 The shared package cam_pkg SHALL hold the state enum typedef and the ADDR_W default constant.
REQ-027 Synchronizer plus edge detect SHALL be one sub-module, cam_sync_edge, instantiated per control signal.

Verification
REQ-028 Arm, then a 4-line x 6-byte frame -> 24 writes, addr 0..23; frame_len=24, line_cnt=4; int_n low; cmd_ack -> int_n high, IDLE.
REQ-029 Arm mid-frame (vsync low, href active) -> no writes until the next vsync falling edge; the following full frame is captured.
REQ-030 ADDR_W=4, 20-byte frame -> 16 writes (addr 0..15); ovf=1, frame_len=16.
REQ-031 cmd_abort at byte 10 of CAPTURE -> no buf_wr_en after the abort cycle; IDLE, int_n=1; line_cnt retained.
REQ-032 cmd_ack and cmd_arm in the same DONE cycle -> WAIT_VS, frame_len=0, int_n=1; the next frame is captured from addr 0.
REQ-033 rst_n_i low mid-CAPTURE -> all outputs at reset values that cycle; no writes without a new cmd_arm.
